// File: rtl/ripple_borrow_sub_pipe_if.sv
// Operand/result bundle for the bit-pipelined ripple-borrow subtractor.
interface ripple_borrow_sub_pipe_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         bout;

    modport master (
        output in_valid, a, b, bin,
        input  out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin,
        output out_valid, diff, bout
    );
endinterface

// File: rtl/ripple_borrow_sub_pipe.sv
// Bit-pipelined ripple-borrow subtractor: diff = a - b - bin (mod 2^W).
// One bit-slice per stage, registered borrow between slices, operand bits
// skewed on the way in and result bits deskewed on the way out so every
// operation emerges fully aligned exactly W cycles after it is accepted.
module ripple_borrow_sub_pipe #(
    parameter int W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ripple_borrow_sub_pipe_if.slave  io
);

    // vld_pipe_q[s] / br_q[s] belong to the operation currently at slice s
    logic [W-1:0] vld_pipe_d, vld_pipe_q;
    logic [W-1:0] br_d, br_q;
    logic [W-1:0] d_slice;
    logic [W-1:0] bo_slice;
    logic [W-1:0] d_align;

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] diff_d, diff_q;
    logic         bout_d, bout_q;

    // valid token and borrow advance one slice per clock; bin enters with slice 0
    always_comb begin
        vld_pipe_d = {vld_pipe_q[W-2:0], io.in_valid};
        br_d       = {bo_slice[W-2:0], io.bin};
    end

    // token/borrow pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            br_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            br_q       <= br_d;
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_bit
        // {a[k], b[k]} skew chain; element j lines up with slice j, so slice k
        // reads element k in the same cycle its borrow reaches br_q[k]
        logic [1:0] ab_sk_d [0:k];
        logic [1:0] ab_sk_q [0:k];
        logic       a_k, b_k;

        // shift operand bits toward slice k
        always_comb begin
            ab_sk_d[0] = {io.a[k], io.b[k]};
            for (int j = 1; j <= k; j++) ab_sk_d[j] = ab_sk_q[j-1];
        end

        // operand skew registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) ab_sk_q[j] <= '0;
            end else begin
                for (int j = 0; j <= k; j++) ab_sk_q[j] <= ab_sk_d[j];
            end
        end

        assign a_k = ab_sk_q[k][1];
        assign b_k = ab_sk_q[k][0];

        // full subtractor slice
        assign d_slice[k]  = a_k ^ b_k ^ br_q[k];
        assign bo_slice[k] = (~a_k & b_k) | (~(a_k ^ b_k) & br_q[k]);

        if (k < W-1) begin : g_dsk
            localparam int D = W-1-k;
            logic dk_d [0:D-1];
            logic dk_q [0:D-1];

            // delay early result bits until the top slice catches up
            always_comb begin
                dk_d[0] = d_slice[k];
                for (int j = 1; j < D; j++) dk_d[j] = dk_q[j-1];
            end

            // result deskew registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < D; j++) dk_q[j] <= 1'b0;
                end else begin
                    for (int j = 0; j < D; j++) dk_q[j] <= dk_d[j];
                end
            end

            assign d_align[k] = dk_q[D-1];
        end else begin : g_top
            assign d_align[k] = d_slice[k];
        end
    end

    // output loads only on a valid token so diff/bout hold across bubbles
    always_comb begin
        out_valid_d = vld_pipe_q[W-1];
        diff_d      = diff_q;
        bout_d      = bout_q;
        if (vld_pipe_q[W-1]) begin
            diff_d = d_align;
            bout_d = bo_slice[W-1];
        end
    end

    // output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;

endmodule

// File: tb/tb_ripple_borrow_sub_pipe.sv
// Self-checking bench: directed cases, an exhaustive back-to-back sweep and
// random traffic, compared every cycle against a cycle-scheduled arithmetic model.
module tb_ripple_borrow_sub_pipe;
    localparam int W    = 4;
    localparam int NSCH = 4096;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_fail;

    // model: result expected in the cycle after edge index, held across bubbles
    bit           sch_vld [0:NSCH-1];
    logic [W-1:0] sch_d   [0:NSCH-1];
    logic         sch_b   [0:NSCH-1];
    logic [W-1:0] hold_d;
    logic         hold_b;

    ripple_borrow_sub_pipe_if #(.W(W)) io ();

    ripple_borrow_sub_pipe #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // every cycle: out_valid, diff and bout against the model
    always @(negedge clk) begin
        if (rst) begin
            hold_d = '0;
            hold_b = 1'b0;
        end else if (sch_vld[cyc]) begin
            hold_d = sch_d[cyc];
            hold_b = sch_b[cyc];
        end
        chk("out_valid", io.out_valid, (!rst && sch_vld[cyc]) ? 1 : 0);
        chk("diff", io.diff, hold_d);
        chk("bout", io.bout, hold_b);
    end

    // drive one cycle of input; sampled on the next rising edge
    task automatic issue(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int d;
        @(posedge clk);
        #1;
        io.in_valid = v;
        io.a        = a;
        io.b        = b;
        io.bin      = bi;
        if (v) begin
            d = int'(a) - int'(b) - int'(bi);
            sch_vld[cyc+1+W] = 1'b1;
            sch_d[cyc+1+W]   = W'(d);
            sch_b[cyc+1+W]   = (int'(a) < int'(b) + int'(bi));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // asynchronous reset pulse in mid-cycle; in-flight work is discarded
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst         = 1'b1;
        io.in_valid = 1'b0;
        #1;
        chk("rst_async_out_valid", io.out_valid, 0);
        chk("rst_async_diff", io.diff, 0);
        chk("rst_async_bout", io.bout, 0);
        for (int i = cyc; i < cyc + W + 4; i++) sch_vld[i] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] v;
        n_chk       = 0;
        n_fail      = 0;
        cyc         = 0;
        hold_d      = '0;
        hold_b      = 1'b0;
        rst         = 1'b1;
        io.in_valid = 1'b0;
        io.a        = '0;
        io.b        = '0;
        io.bin      = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_out_valid", io.out_valid, 0);
        chk("reset_diff", io.diff, 0);
        chk("reset_bout", io.bout, 0);
        rst = 1'b0;

        // single op, underflow and wrap cases, each isolated
        idle(2);
        issue(1'b1, 4'd9, 4'd3, 1'b0);
        idle(6);
        issue(1'b1, 4'd3, 4'd9, 1'b0);
        idle(6);
        issue(1'b1, 4'd0, 4'd0, 1'b1);
        idle(6);
        issue(1'b1, 4'd15, 4'd0, 1'b0);
        idle(6);

        // back-to-back stream
        issue(1'b1, 4'd9, 4'd3, 1'b0);
        issue(1'b1, 4'd3, 4'd9, 1'b0);
        issue(1'b1, 4'd15, 4'd15, 1'b1);
        issue(1'b1, 4'd8, 4'd1, 1'b1);
        idle(6);

        // bubble hold with toggling don't-care inputs
        issue(1'b1, 4'd12, 4'd5, 1'b0);
        idle(2);
        issue(1'b1, 4'd1, 4'd1, 1'b0);
        idle(6);

        // reset while three ops are in flight
        issue(1'b1, 4'd7, 4'd2, 1'b0);
        issue(1'b1, 4'd10, 4'd4, 1'b1);
        issue(1'b1, 4'd6, 4'd6, 1'b0);
        idle(2);
        pulse_reset();
        issue(1'b1, 4'd5, 4'd2, 1'b0);
        idle(6);

        // exhaustive back-to-back sweep
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            issue(1'b1, v[7:4], v[3:0], v[8]);
        end
        idle(6);

        // random traffic with random bubbles
        for (int i = 0; i < 300; i++)
            issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom));
        idle(W + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
